// File: rtl/seq_addsub_pkg.sv
// Shared constants for the sequential add/sub calculator:
// default width and FSM state encodings.
package seq_addsub_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ST_GET_A = 2'b00;
  localparam logic [1:0] ST_GET_B = 2'b01;
  localparam logic [1:0] ST_CALC  = 2'b10;
  localparam logic [1:0] ST_SHOW  = 2'b11;

endpackage

// File: rtl/seq_addsub_if.sv
// Operator-panel bundle: switches/buttons in,
// operands, result and flags out.
interface seq_addsub_if
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] D;
  logic             enter;
  logic             sub;
  logic             accum;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;
  logic             ovf_sticky;
  logic             valid;
  logic [1:0]       state;

  modport master (
    output D, enter, sub, accum,
    input  A, B, S, cout, ovf,
    input  ovf_sticky, valid, state
  );

  modport slave (
    input  D, enter, sub, accum,
    output A, B, S, cout, ovf,
    output ovf_sticky, valid, state
  );

endinterface

// File: rtl/seq_addsub_rca.sv
// Ripple-carry adder/subtractor; sub inverts b
// and doubles as the carry-in.
module addsub_rca #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] w_bx;
  logic [WIDTH:0]   w_c;

  assign w_bx   = b ^ {WIDTH{sub}};
  assign w_c[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]     = a[i] ^ w_bx[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & w_bx[i])
                    | (w_c[i] & (a[i] ^ w_bx[i]));
  end

  assign cout = w_c[WIDTH];
  assign ovf  = (a[WIDTH-1] == w_bx[WIDTH-1])
              & (s[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/seq_addsub.sv
// Button-driven calculator: edge detect, FSM and
// operand/result/flag registers around addsub_rca.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic        clock,
  input  logic        Reset,
  seq_addsub_if.slave bus
);

  logic [1:0]       r_state;
  logic             r_enter_q;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_ovf_sticky;
  logic             r_valid;

  logic             w_edge;
  logic [WIDTH-1:0] w_s;
  logic             w_cout;
  logic             w_ovf;

  assign w_edge = bus.enter & ~r_enter_q;

  addsub_rca #(
    .WIDTH(WIDTH)
  ) u_rca (
    .a    (r_a),
    .b    (r_b),
    .sub  (bus.sub),
    .s    (w_s),
    .cout (w_cout),
    .ovf  (w_ovf)
  );

  always_ff @(posedge clock) begin
    if (Reset) begin
      r_state      <= ST_GET_A;
      r_enter_q    <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_s          <= '0;
      r_cout       <= 1'b0;
      r_ovf        <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      r_enter_q <= bus.enter;
      case (r_state)
        ST_GET_A: begin
          if (w_edge) begin
            r_a          <= bus.D;
            r_ovf_sticky <= 1'b0;
            r_state      <= ST_GET_B;
          end
        end
        ST_GET_B: begin
          if (w_edge) begin
            r_b     <= bus.D;
            r_state <= ST_CALC;
          end
        end
        // Single-cycle evaluate; edges here are dropped.
        ST_CALC: begin
          r_s          <= w_s;
          r_cout       <= w_cout;
          r_ovf        <= w_ovf;
          r_ovf_sticky <= r_ovf_sticky | w_ovf;
          r_valid      <= 1'b1;
          r_state      <= ST_SHOW;
        end
        default: begin
          if (w_edge) begin
            r_valid <= 1'b0;
            if (bus.accum) begin
              r_a     <= r_s;
              r_b     <= bus.D;
              r_state <= ST_CALC;
            end else begin
              r_a          <= bus.D;
              r_ovf_sticky <= 1'b0;
              r_state      <= ST_GET_B;
            end
          end
        end
      endcase
    end
  end

  assign bus.A          = r_a;
  assign bus.B          = r_b;
  assign bus.S          = r_s;
  assign bus.cout       = r_cout;
  assign bus.ovf        = r_ovf;
  assign bus.ovf_sticky = r_ovf_sticky;
  assign bus.valid      = r_valid;
  assign bus.state      = r_state;

endmodule
